// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the external memory bus sequencer:
// one-hot FSM states, requester indices and the encoded grant type.
package mcu_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SETUP  = 4'b0010,
        ST_ACCESS = 4'b0100,
        ST_DONE   = 4'b1000
    } state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_RD    = 1;
    localparam int REQ_WR    = 2;
    localparam int NUM_REQ   = 3;

    typedef logic [1:0] grant_t;

    localparam grant_t GNT_FETCH = grant_t'(REQ_FETCH);
    localparam grant_t GNT_RD    = grant_t'(REQ_RD);
    localparam grant_t GNT_WR    = grant_t'(REQ_WR);

    // Collapses a one-hot grant vector into the 2-bit requester index.
    function automatic grant_t encode_grant(input logic [NUM_REQ-1:0] onehot);
        encode_grant = GNT_FETCH;
        if (onehot[REQ_RD]) encode_grant = GNT_RD;
        if (onehot[REQ_WR]) encode_grant = GNT_WR;
    endfunction

endpackage

// File: rtl/bus_req_arbiter.sv
// Fixed-priority arbiter (write > read > fetch) with a starvation counter
// that forces a fetch grant after STARVE_LIMIT rd/wr grants while fetch waits.
module bus_req_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = req[REQ_FETCH] && (starve_cnt == LIMIT_VAL);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a
        // path that leaves it unassigned would infer a latch.
        grant = '0;
        if (arb_en) begin
            if (starved)             grant[REQ_FETCH] = 1'b1;
            else if (req[REQ_WR])    grant[REQ_WR]    = 1'b1;
            else if (req[REQ_RD])    grant[REQ_RD]    = 1'b1;
            else if (req[REQ_FETCH]) grant[REQ_FETCH] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!req[REQ_FETCH] || grant[REQ_FETCH]) begin
            starve_cnt <= '0;
        end else if ((grant[REQ_WR] || grant[REQ_RD]) && (starve_cnt != LIMIT_VAL)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Shares the 8-bit external address/data bus between fetch, operand read and
// write-back: arbitrates in IDLE, then runs SETUP -> ACCESS -> DONE per access.
module mem_bus_sequencer
    import mcu_bus_pkg::*;
#(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_ack,
    output logic [7:0] fetch_data,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic [7:0] rd_data,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic [7:0] addr_bus,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic       read_en,
    output logic       write_en,
    output logic       busy
);

    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    grant_t             grant_q;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] grant_vec;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [7:0]         addr_q;
    logic [7:0]         wdata_q;
    logic [7:0]         fetch_data_q;
    logic [7:0]         rd_data_q;
    logic               arb_en;
    logic               access_last;

    always_comb begin
        req_vec            = '0;
        req_vec[REQ_FETCH] = fetch_req;
        req_vec[REQ_RD]    = rd_req;
        req_vec[REQ_WR]    = wr_req;
    end

    assign arb_en      = (state == ST_IDLE);
    assign access_last = (state == ST_ACCESS) && (wait_cnt == '0);

    bus_req_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clk    (clk),
        .reset  (reset),
        .arb_en (arb_en),
        .req    (req_vec),
        .grant  (grant_vec)
    );

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        read_en    = 1'b0;
        write_en   = 1'b0;
        data_oe    = 1'b0;
        fetch_ack  = 1'b0;
        rd_ack     = 1'b0;
        wr_ack     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|grant_vec) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (grant_q == GNT_WR) begin
                    write_en = 1'b1;
                    data_oe  = 1'b1;
                end else begin
                    read_en  = 1'b1;
                end
                if (wait_cnt == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                fetch_ack  = (grant_q == GNT_FETCH);
                rd_ack     = (grant_q == GNT_RD);
                wr_ack     = (grant_q == GNT_WR);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address and write data are latched at grant so requesters may change
    // their inputs mid-transaction without disturbing the bus cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q      <= GNT_FETCH;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            wait_cnt     <= '0;
            fetch_data_q <= 8'h00;
            rd_data_q    <= 8'h00;
        end else begin
            if (arb_en && (|grant_vec)) begin
                grant_q <= encode_grant(grant_vec);
                if (grant_vec[REQ_WR]) begin
                    addr_q  <= wr_addr;
                    wdata_q <= wr_data;
                end else if (grant_vec[REQ_RD]) begin
                    addr_q  <= rd_addr;
                end else begin
                    addr_q  <= fetch_addr;
                end
            end

            if (state == ST_SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ST_ACCESS) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end

            if (access_last) begin
                if (grant_q == GNT_FETCH)   fetch_data_q <= data_in;
                else if (grant_q == GNT_RD) rd_data_q    <= data_in;
            end
        end
    end

    assign addr_bus   = addr_q;
    assign data_out   = wdata_q;
    assign fetch_data = fetch_data_q;
    assign rd_data    = rd_data_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench for mem_bus_sequencer: directed bus-cycle scenarios
// followed by randomized traffic scored against a transaction-level model.
module tb_mem_bus_sequencer;

    localparam int W = 1;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req, rd_req, wr_req;
    logic [7:0] fetch_addr, rd_addr, wr_addr, wr_data, data_in;
    logic       fetch_ack, rd_ack, wr_ack;
    logic [7:0] fetch_data, rd_data, addr_bus, data_out;
    logic       data_oe, read_en, write_en, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_sequencer #(
        .WAIT_CYCLES  (W),
        .STARVE_LIMIT (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .addr_bus   (addr_bus),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_in    (data_in),
        .read_en    (read_en),
        .write_en   (write_en),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return at the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int who, input logic v);
        case (who)
            0:       fetch_req = v;
            1:       rd_req    = v;
            default: wr_req    = v;
        endcase
    endtask

    // Waits (bounded) for the next ack; who = 0 fetch, 1 rd, 2 wr, -1 timeout.
    task automatic wait_ack(input bit drop, output int who);
        who = -1;
        for (int i = 0; (i < 8 * (W + 3)) && (who < 0); i++) begin
            tick();
            if (fetch_ack || rd_ack || wr_ack) begin
                check("ack_onehot", $countones({fetch_ack, rd_ack, wr_ack}), 1);
                who = wr_ack ? 2 : (rd_ack ? 1 : 0);
                if (drop) set_req(who, 1'b0);
            end
        end
        if (who < 0) check("ack_timeout", 0, 1);
    endtask

    task automatic rand_phase(input int ncyc);
        int         k;
        int         g;
        int         m_gnt;
        int         m_starve;
        logic [7:0] m_addr, m_wdata, m_fdata, m_rdata;
        bit         acc;
        logic [3:0] e_ctl;
        logic [2:0] e_ack;
        // Model phase k: 0 idle, 1 setup, 2..W+1 access, W+2 done.
        k = 0; m_gnt = 0; m_starve = 0;
        m_addr = 8'h00; m_wdata = 8'h00; m_fdata = 8'h00; m_rdata = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            acc   = (k >= 2) && (k <= W + 1);
            e_ctl = {k != 0, acc && (m_gnt != 2), acc && (m_gnt == 2), acc && (m_gnt == 2)};
            e_ack = (k == W + 2) ? 3'(1 << m_gnt) : 3'b000;
            check("rnd_ctl", {busy, read_en, write_en, data_oe}, e_ctl);
            check("rnd_ack", {wr_ack, rd_ack, fetch_ack}, e_ack);
            check("rnd_addr", addr_bus, m_addr);
            check("rnd_dout", data_out, m_wdata);
            check("rnd_fdata", fetch_data, m_fdata);
            check("rnd_rdata", rd_data, m_rdata);

            if ((k == W + 2) && ($urandom_range(0, 3) != 0)) set_req(m_gnt, 1'b0);
            if ((k >= 1) && (k <= W + 1)) begin
                if ($urandom_range(0, 7) == 0) set_req(m_gnt, 1'b0);
                if ($urandom_range(0, 1) == 0) begin
                    case (m_gnt)
                        0: fetch_addr = 8'($urandom);
                        1: rd_addr    = 8'($urandom);
                        default: begin
                            wr_addr = 8'($urandom);
                            wr_data = 8'($urandom);
                        end
                    endcase
                end
            end
            if (!fetch_req && ($urandom_range(0, 2) == 0)) begin
                fetch_req  = 1'b1;
                fetch_addr = 8'($urandom);
            end
            if (!rd_req && ($urandom_range(0, 3) == 0)) begin
                rd_req  = 1'b1;
                rd_addr = 8'($urandom);
            end
            if (!wr_req && ($urandom_range(0, 3) == 0)) begin
                wr_req  = 1'b1;
                wr_addr = 8'($urandom);
                wr_data = 8'($urandom);
            end
            data_in = 8'($urandom);

            if (k == 0) begin
                g = -1;
                if (fetch_req && (m_starve == S)) g = 0;
                else if (wr_req)                  g = 2;
                else if (rd_req)                  g = 1;
                else if (fetch_req)               g = 0;
                if ((g == 0) || !fetch_req) m_starve = 0;
                else if (g > 0)             m_starve = (m_starve < S) ? m_starve + 1 : S;
                if (g >= 0) begin
                    m_gnt  = g;
                    m_addr = (g == 2) ? wr_addr : ((g == 1) ? rd_addr : fetch_addr);
                    if (g == 2) m_wdata = wr_data;
                    k = 1;
                end
            end else begin
                if (!fetch_req) m_starve = 0;
                if (k == W + 1) begin
                    if (m_gnt == 0)      m_fdata = data_in;
                    else if (m_gnt == 1) m_rdata = data_in;
                end
                k = (k == W + 2) ? 0 : k + 1;
            end
            tick();
        end
        fetch_req = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who;
        int exp_seq[10] = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};

        reset = 1'b1;
        fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        fetch_addr = 8'h01; rd_addr = 8'h02; wr_addr = 8'h03; wr_data = 8'h04;
        data_in = 8'h00;

        // Reset with every request asserted.
        tick();
        tick();
        check("rst_ctl", {busy, read_en, write_en, data_oe}, 4'b0000);
        check("rst_ack", {fetch_ack, rd_ack, wr_ack}, 3'b000);
        check("rst_bus", {addr_bus, data_out}, 16'h0000);
        check("rst_data", {fetch_data, rd_data}, 16'h0000);
        fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_idle", busy, 1'b0);

        // Single fetch.
        fetch_req = 1'b1; fetch_addr = 8'h10;
        tick();
        check("f_setup_addr", addr_bus, 8'h10);
        check("f_setup_ctl", {busy, read_en, fetch_ack}, 3'b100);
        data_in = 8'hE4;
        for (int i = 0; i < W; i++) begin
            tick();
            check("f_access_ctl", {read_en, write_en, data_oe, fetch_ack}, 4'b1000);
        end
        tick();
        check("f_ack", {fetch_ack, rd_ack, wr_ack, read_en}, 4'b1000);
        check("f_data", fetch_data, 8'hE4);
        fetch_req = 1'b0; data_in = 8'h00;
        tick();
        check("f_idle", {busy, fetch_ack}, 2'b00);
        check("f_data_hold", fetch_data, 8'hE4);

        // Single write.
        wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h5A;
        tick();
        check("w_setup_addr", addr_bus, 8'h30);
        check("w_setup_ctl", {read_en, write_en, data_oe}, 3'b000);
        wr_addr = 8'hFF; wr_data = 8'hFF;
        for (int i = 0; i < W; i++) begin
            tick();
            check("w_access_ctl", {read_en, write_en, data_oe}, 3'b011);
            check("w_data_out", data_out, 8'h5A);
            check("w_addr_held", addr_bus, 8'h30);
        end
        tick();
        check("w_ack", {wr_ack, rd_ack, fetch_ack, write_en, data_oe, read_en}, 6'b100000);
        wr_req = 1'b0;
        tick();
        check("w_ack_once", {wr_ack, busy}, 2'b00);

        // Simultaneous requests: serviced wr, rd, fetch.
        data_in = 8'h3C;
        fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        fetch_addr = 8'h11; rd_addr = 8'h22; wr_addr = 8'h33; wr_data = 8'h44;
        wait_ack(1'b1, who); check("order_0", who, 2);
        wait_ack(1'b1, who); check("order_1", who, 1);
        check("order_rd_data", rd_data, 8'h3C);
        wait_ack(1'b1, who); check("order_2", who, 0);
        tick();
        check("order_idle", busy, 1'b0);

        // Starvation: all requests held high, fetch forced after S rd/wr grants.
        fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_ack(1'b0, who);
            check($sformatf("starve_%0d", i), who, exp_seq[i]);
        end
        fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        tick();
        check("starve_idle", busy, 1'b0);

        // Reset asserted during ACCESS of a read.
        rd_req = 1'b1; rd_addr = 8'h77;
        tick();
        data_in = 8'hAA;
        tick();
        check("rr_access", read_en, 1'b1);
        reset = 1'b1; rd_req = 1'b0;
        tick();
        check("rr_ctl", {read_en, rd_ack, busy}, 3'b000);
        check("rr_data", rd_data, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            check("rr_no_ack", {rd_ack, busy}, 2'b00);
        end

        // Randomized traffic against the transaction-level model.
        rand_phase(800);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
